// File: rtl/la_and3q_pkg.sv
// la_and3q_pkg
//   Shared definitions for the la_and3_qual input qualifier.
//   - state_t  : 2-bit FSM encoding (IDLE=0, QUAL=1, ON=2, DROP=3)
//   - SYNC_MIN : smallest synchronizer depth the qualifier will build
package la_and3q_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    ON   = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam int SYNC_MIN = 2;

endpackage

// File: rtl/la_and3q_sync.sv
// la_and3q_sync
//   Single-bit synchronizer chain, STAGES flops deep, cleared by an
//   asynchronous active-high reset.
// Ports
//   clk    in  1  clock
//   reset  in  1  asynchronous, active-high reset
//   d      in  1  asynchronous input
//   q      out 1  synchronized output (last flop of the chain)
module la_and3q_sync
  import la_and3q_pkg::*;
#(
  parameter int STAGES = SYNC_MIN
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {STAGES{1'b0}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/la_and3_qual.sv
// la_and3_qual
//   Qualifier in front of a 3-input AND gate. a, b and c are synchronized,
//   ANDed into s, and s must hold high for the programmable threshold before
//   z asserts; z is held through drop-outs shorter than the release threshold.
// Parameters
//   PROP        implementation property string (carried through only)
//   SYNCSTAGES  synchronizer flops per input (clamped to at least SYNC_MIN)
//   CNTW        width of the counter and the thresholds
// Ports
//   clk      in   1     clock
//   reset    in   1     asynchronous, active-high reset
//   a, b, c  in   1     asynchronous inputs
//   hold     in   CNTW  assert threshold H, sampled live
//   rel      in   CNTW  deassert (release) threshold R, sampled live;
//                       'release' is a reserved word, hence the short name
//   z        out  1     qualified AND (registered)
//   rise     out  1     one-cycle pulse on z 0->1
//   fall     out  1     one-cycle pulse on z 1->0
//   busy     out  1     FSM is in QUAL or DROP
//   aborts   out  CNTW  saturating count of QUAL->IDLE aborts; present only
//                       when LA_AND3Q_ABORTCNT_EN is defined
module la_and3_qual
  import la_and3q_pkg::*;
#(
  parameter string PROP       = "DEFAULT",
  parameter int    SYNCSTAGES = 2,
  parameter int    CNTW       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a,
  input  logic            b,
  input  logic            c,
  input  logic [CNTW-1:0] hold,
  input  logic [CNTW-1:0] rel,
  output logic            z,
  output logic            rise,
  output logic            fall,
  output logic            busy
`ifdef LA_AND3Q_ABORTCNT_EN
  ,
  output logic [CNTW-1:0] aborts
`endif
);

  localparam int STAGES = (SYNCSTAGES < SYNC_MIN) ? SYNC_MIN : SYNCSTAGES;

  // PROP is for implementation tools; no logic here depends on its value.
  if (PROP == "") begin : g_prop_empty
  end

  logic a_sync;
  logic b_sync;
  logic c_sync;
  logic s;

  la_and3q_sync #(.STAGES(STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(a), .q(a_sync));
  la_and3q_sync #(.STAGES(STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(b), .q(b_sync));
  la_and3q_sync #(.STAGES(STAGES)) u_sync_c (.clk(clk), .reset(reset), .d(c), .q(c_sync));

  assign s = a_sync & b_sync & c_sync;

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic [CNTW:0]   cnt_inc;
  logic            hold_met;
  logic            rel_met;
  logic            rise_nxt;
  logic            fall_nxt;

  // cnt+1 is formed one bit wider so "cnt >= T-1" never underflows when a
  // threshold is lowered to zero mid-count.
  assign cnt_inc  = {1'b0, cnt} + {{CNTW{1'b0}}, 1'b1};
  assign hold_met = (cnt_inc >= {1'b0, hold});
  assign rel_met  = (cnt_inc >= {1'b0, rel});

  // Next-state, counter and pulse decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          if (hold == {CNTW{1'b0}}) begin
            state_nxt = ON;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = QUAL;
            cnt_nxt   = {CNTW{1'b0}};
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      QUAL: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (hold_met) begin
          state_nxt = ON;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc[CNTW-1:0];
        end
      end
      ON: begin
        if (!s) begin
          if (rel == {CNTW{1'b0}}) begin
            state_nxt = IDLE;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = DROP;
            cnt_nxt   = {CNTW{1'b0}};
          end
        end else begin
          state_nxt = ON;
        end
      end
      DROP: begin
        if (s) begin
          state_nxt = ON;
        end else if (rel_met) begin
          state_nxt = IDLE;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc[CNTW-1:0];
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = {CNTW{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs; z/busy decode the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= {CNTW{1'b0}};
      z     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      z     <= (state_nxt == ON) || (state_nxt == DROP);
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= (state_nxt == QUAL) || (state_nxt == DROP);
    end
  end

`ifdef LA_AND3Q_ABORTCNT_EN
  logic abort;

  // A qualification is aborted when s drops while still in QUAL
  assign abort = (state == QUAL) && !s;

  // Saturating abort counter, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborts <= {CNTW{1'b0}};
    end else if (abort && (aborts != {CNTW{1'b1}})) begin
      aborts <= aborts + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      aborts <= aborts;
    end
  end
`endif

endmodule
